// File: rtl/node_injection_scheduler.sv
// node_injection_scheduler
//   Injection controller for one mesh node's local input port. It shares that
//   port among NUM_REQ traffic sources using packet-level round-robin
//   arbitration. Each granted packet gets one VC. The packet is cut into
//   HEAD/BODY/TAIL (or a single HEADTAIL) flit stream, and every flit waits on
//   the per-VC on/off credit of the port.
//
// Flit layout on data_o (MSB first):
//   [FLIT_W-1 -: 2]           label: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL
//   [FLIT_DATA_SIZE +: VC_SIZE] vc_id
//   [FLIT_DATA_SIZE-1:0]      head: {x_dest, y_dest, head_pl}; body/tail: bt_pl
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_i             per-requester packet pending
//   x_dest_i/y_dest_i per-requester destination, sampled with the head flit
//   len_i             per-requester length in flits, sampled at grant
//                     (0 -> 1, >MAX_PKT_LEN -> MAX_PKT_LEN)
//   payload_i         per-requester current payload word
//   flit_ack_o        combinational one-hot; the payload word is consumed this edge
//   gnt_o             registered one-hot owner of the port
//   done_o            one-cycle pulse aligned with the tail flit on data_o
//   busy_o            high while a packet is being sent
//   data_o            flit into the router; is_valid_o qualifies it
//   is_on_off_i       per-VC on/off credit
//   is_allocatable_i  per-VC free indication
module node_injection_scheduler #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned MAX_PKT_LEN      = 8,
  parameter int unsigned LEN_W            = $clog2(MAX_PKT_LEN + 1),
  parameter int unsigned VC_NUM           = 4,
  parameter int unsigned VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int unsigned DEST_ADDR_SIZE_X = 4,
  parameter int unsigned DEST_ADDR_SIZE_Y = 4,
  parameter int unsigned FLIT_DATA_SIZE   = 32,
  parameter int unsigned FLIT_W           = 2 + VC_SIZE + FLIT_DATA_SIZE
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQ-1:0]                               req_i,
  input  logic [NUM_REQ-1:0][DEST_ADDR_SIZE_X-1:0]         x_dest_i,
  input  logic [NUM_REQ-1:0][DEST_ADDR_SIZE_Y-1:0]         y_dest_i,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]                    len_i,
  input  logic [NUM_REQ-1:0][FLIT_DATA_SIZE-1:0]           payload_i,
  output logic [NUM_REQ-1:0]                               flit_ack_o,
  output logic [NUM_REQ-1:0]                               gnt_o,
  output logic [NUM_REQ-1:0]                               done_o,
  output logic                                             busy_o,
  output logic [FLIT_W-1:0]                                data_o,
  output logic                                             is_valid_o,
  input  logic [VC_NUM-1:0]                                is_on_off_i,
  input  logic [VC_NUM-1:0]                                is_allocatable_i
);

  localparam int unsigned REQ_W             = $clog2(NUM_REQ);
  localparam int unsigned HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  localparam logic [1:0] LblHead     = 2'b00;
  localparam logic [1:0] LblBody     = 2'b01;
  localparam logic [1:0] LblTail     = 2'b10;
  localparam logic [1:0] LblHeadTail = 2'b11;

  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_PKT_LEN);

  typedef enum logic {StIdle, StSend} state_t;

  state_t             state_q;
  logic [REQ_W-1:0]   rr_ptr_q;
  logic [REQ_W-1:0]   cur_req_q;
  logic [VC_SIZE-1:0] cur_vc_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;

  // Arbitration results
  logic               req_found;
  logic [REQ_W-1:0]   win;
  logic [REQ_W-1:0]   cand;
  logic               vc_found;
  logic [VC_SIZE-1:0] vc_win;
  logic [LEN_W-1:0]   len_sel;
  logic [LEN_W-1:0]   len_eff;

  // Flit assembly
  logic                      cur_on;
  logic                      last_flit;
  logic [1:0]                label;
  logic [FLIT_DATA_SIZE-1:0] flit_data;
  logic [FLIT_W-1:0]         flit_next;

  // Round-robin search starting at rr_ptr_q; lowest-index eligible VC.
  always_comb begin
    req_found = 1'b0;
    win       = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = REQ_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!req_found && req_i[cand]) begin
        req_found = 1'b1;
        win       = cand;
      end
    end

    vc_found = 1'b0;
    vc_win   = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (!vc_found && is_allocatable_i[v] && is_on_off_i[v]) begin
        vc_found = 1'b1;
        vc_win   = VC_SIZE'(v);
      end
    end

    len_sel = len_i[win];
    if (len_sel == '0) begin
      len_eff = LenOne;
    end else if (len_sel > LenMax) begin
      len_eff = LenMax;
    end else begin
      len_eff = len_sel;
    end
  end

  always_comb begin
    cur_on    = is_on_off_i[cur_vc_q];
    last_flit = (cnt_q == len_q - LenOne);

    if (len_q == LenOne) begin
      label = LblHeadTail;
    end else if (cnt_q == '0) begin
      label = LblHead;
    end else if (last_flit) begin
      label = LblTail;
    end else begin
      label = LblBody;
    end

    // Head flits carry the destination plus the low payload bits.
    if (cnt_q == '0) begin
      flit_data = {x_dest_i[cur_req_q], y_dest_i[cur_req_q],
                   payload_i[cur_req_q][HEAD_PAYLOAD_SIZE-1:0]};
    end else begin
      flit_data = payload_i[cur_req_q];
    end
    flit_next = {label, cur_vc_q, flit_data};

    flit_ack_o = '0;
    if (state_q == StSend) begin
      flit_ack_o[cur_req_q] = cur_on;
    end
    busy_o = (state_q == StSend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cur_req_q  <= '0;
      cur_vc_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      is_valid_o <= 1'b0;
      data_o     <= '0;
    end else begin
      done_o     <= '0;
      is_valid_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_found && vc_found) begin
            cur_req_q <= win;
            cur_vc_q  <= vc_win;
            len_q     <= len_eff;
            cnt_q     <= '0;
            gnt_o     <= NUM_REQ'(1) << win;
            rr_ptr_q  <= (win == REQ_W'(NUM_REQ - 1)) ? '0 : win + REQ_W'(1);
            state_q   <= StSend;
          end
        end
        StSend: begin
          // A stall simply skips the emit; cnt_q holds.
          if (cur_on) begin
            data_o     <= flit_next;
            is_valid_o <= 1'b1;
            cnt_q      <= cnt_q + LenOne;
            if (last_flit) begin
              state_q <= StIdle;
              gnt_o   <= '0;
              done_o  <= NUM_REQ'(1) << cur_req_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_node_injection_scheduler.sv
// Self-checking bench for node_injection_scheduler: directed scenarios push
// expected flits into a scoreboard queue, a monitor pops on every valid flit.
module tb_node_injection_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned ML = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned VN = 4;
  localparam int unsigned VS = 2;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 4;
  localparam int unsigned FD = 32;
  localparam int unsigned FW = 2 + VS + FD;
  localparam int unsigned HP = FD - XW - YW;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_i;
  logic [NR-1:0][XW-1:0]    x_dest_i;
  logic [NR-1:0][YW-1:0]    y_dest_i;
  logic [NR-1:0][LW-1:0]    len_i;
  logic [NR-1:0][FD-1:0]    payload_i;
  logic [NR-1:0]            flit_ack_o;
  logic [NR-1:0]            gnt_o;
  logic [NR-1:0]            done_o;
  logic                     busy_o;
  logic [FW-1:0]            data_o;
  logic                     is_valid_o;
  logic [VN-1:0]            is_on_off_i;
  logic [VN-1:0]            is_allocatable_i;

  node_injection_scheduler #(
    .NUM_REQ          (NR),
    .MAX_PKT_LEN      (ML),
    .LEN_W            (LW),
    .VC_NUM           (VN),
    .VC_SIZE          (VS),
    .DEST_ADDR_SIZE_X (XW),
    .DEST_ADDR_SIZE_Y (YW),
    .FLIT_DATA_SIZE   (FD),
    .FLIT_W           (FW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req_i),
    .x_dest_i         (x_dest_i),
    .y_dest_i         (y_dest_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .flit_ack_o       (flit_ack_o),
    .gnt_o            (gnt_o),
    .done_o           (done_o),
    .busy_o           (busy_o),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] flit;
    logic [NR-1:0] done;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            pending[NR];
  int            idx[NR];
  int            exp_idx[NR];
  logic [NR-1:0] gnt_seen;
  logic          prev_valid;

  function automatic logic [FD-1:0] word(input int r, input int i);
    return {8'(8'hA0 + r), 8'h5C, 16'(i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Expected flit stream for one packet of requester r.
  task automatic push_pkt(input int r, input int len_raw, input int vc);
    int            l;
    logic [1:0]    lbl;
    logic [FD-1:0] w;
    logic [FD-1:0] d;
    logic [VS-1:0] vcb;
    exp_t          e;
    l   = (len_raw == 0) ? 1 : ((len_raw > ML) ? ML : len_raw);
    vcb = VS'(vc);
    for (int k = 0; k < l; k++) begin
      if (l == 1)           lbl = 2'b11;
      else if (k == 0)      lbl = 2'b00;
      else if (k == l - 1)  lbl = 2'b10;
      else                  lbl = 2'b01;
      w = word(r, exp_idx[r] + k);
      d = (k == 0) ? {x_dest_i[r], y_dest_i[r], w[HP-1:0]} : w;
      e.flit = {lbl, vcb, d};
      e.done = (k == l - 1) ? (NR'(1) << r) : '0;
      exp_q.push_back(e);
    end
    exp_idx[r] += l;
  endtask

  function automatic bit all_clear();
    for (int r = 0; r < NR; r++) if (pending[r] != 0) return 1'b0;
    return (exp_q.size() == 0) && !busy_o && !is_valid_o;
  endfunction

  task automatic wait_idle(input int n);
    int c;
    c = 0;
    while (c < n && !all_clear()) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= n) begin
      bad++;
      $display("FAIL wait_idle: got timeout after %0d cycles want idle, queue=%0d", c, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int n);
    int seen;
    int c;
    seen = 0;
    c = 0;
    while (seen < n && c < 100) begin
      @(negedge clk);
      c++;
      if (is_valid_o) seen++;
    end
    total++;
    if (seen < n) begin
      bad++;
      $display("FAIL wait_valid: got %0d flits want %0d", seen, n);
    end
  endtask

  task automatic head_latency(input string name);
    int edges;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (is_valid_o) break;
    end
    check(name, 64'(edges), 64'd2);
  endtask

  // Monitor: scoreboard pops plus per-cycle invariants.
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("gnt_onehot", 64'($onehot0(gnt_o)), 64'd1);
        check("ack_within_gnt", 64'(flit_ack_o & ~gnt_o), 64'd0);
        if (is_valid_o) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_flit: got %0h want none", data_o);
          end else begin
            e = exp_q.pop_front();
            check("flit", 64'(data_o), 64'(e.flit));
            check("done_with_flit", 64'(done_o), 64'(e.done));
            if (e.flit[FW-1 -: 2] == 2'b00 || e.flit[FW-1 -: 2] == 2'b11)
              check("bubble_before_head", 64'(prev_valid), 64'd0);
          end
        end else begin
          check("done_idle", 64'(done_o), 64'd0);
        end
        prev_valid = is_valid_o;
      end
    end
  end

  // Payload sources: advance the word after each acknowledged edge.
  initial begin
    logic [NR-1:0] ack_s;
    for (int r = 0; r < NR; r++) begin
      idx[r] = 0;
      payload_i[r] = word(r, 0);
    end
    forever begin
      @(negedge clk);
      #4;
      ack_s = flit_ack_o;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (rst) idx[r] = 0;
        else if (ack_s[r]) idx[r]++;
        payload_i[r] = word(r, idx[r]);
      end
    end
  end

  // Requesters: hold req while packets are pending; one packet leaves per grant.
  initial begin
    gnt_seen = '0;
    req_i = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int r = 0; r < NR; r++) begin
        if (gnt_o[r] && !gnt_seen[r] && pending[r] > 0) pending[r]--;
        req_i[r] = (pending[r] > 0);
      end
      gnt_seen = gnt_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1;
    is_on_off_i = '1;
    is_allocatable_i = '1;
    for (int r = 0; r < NR; r++) begin
      pending[r] = 0;
      exp_idx[r] = 0;
      x_dest_i[r] = XW'(r + 1);
      y_dest_i[r] = YW'(r + 5);
      len_i[r] = LW'(2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ack", 64'(flit_ack_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(is_valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round robin, all four requesters, len 2: order 0,1,2,3,0.
    push_pkt(0, 2, 0);
    push_pkt(1, 2, 0);
    push_pkt(2, 2, 0);
    push_pkt(3, 2, 0);
    push_pkt(0, 2, 0);
    pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
    wait_idle(200);

    // Single requester 0, len 3, dest (1,2).
    x_dest_i[0] = XW'(1);
    y_dest_i[0] = YW'(2);
    len_i[0] = LW'(3);
    a0 = idx[0];
    push_pkt(0, 3, 0);
    pending[0] = 1;
    @(negedge clk);
    #3;
    head_latency("req_to_head_latency");
    wait_idle(50);
    check("ack_count_r0", 64'(idx[0] - a0), 64'd3);

    // HEADTAIL for len 1 and len 0; clamp of an oversize length.
    x_dest_i[2] = XW'(3);
    y_dest_i[2] = YW'(4);
    len_i[2] = LW'(1);
    push_pkt(2, 1, 0);
    pending[2] = 1;
    wait_idle(50);
    len_i[2] = LW'(0);
    push_pkt(2, 0, 0);
    pending[2] = 1;
    wait_idle(50);
    len_i[3] = LW'(15);
    push_pkt(3, 15, 0);
    pending[3] = 1;
    wait_idle(50);

    // Stall on VC1 for two cycles in the middle of a len 4 packet.
    is_allocatable_i = 4'b1110;
    len_i[1] = LW'(4);
    push_pkt(1, 4, 1);
    pending[1] = 1;
    wait_valid(2);
    #1;
    is_on_off_i[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check("stall_valid", 64'(is_valid_o), 64'd0);
      check("stall_ack", 64'(flit_ack_o), 64'd0);
    end
    #1;
    is_on_off_i = '1;
    @(negedge clk);
    check("stall_resume", 64'(is_valid_o), 64'd1);
    wait_idle(50);

    // No allocatable VC: the request waits, then VC2 frees up.
    is_allocatable_i = '0;
    len_i[3] = LW'(2);
    push_pkt(3, 2, 2);
    pending[3] = 1;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      check("noalloc_gnt", 64'(gnt_o), 64'd0);
      check("noalloc_valid", 64'(is_valid_o), 64'd0);
    end
    @(posedge clk);
    #1;
    is_allocatable_i = 4'b0100;
    head_latency("alloc_to_head_latency");
    wait_idle(50);

    // Reset in the middle of a len 5 packet from requester 0 (pointer -> 1).
    is_allocatable_i = '1;
    len_i[0] = LW'(5);
    push_pkt(0, 5, 0);
    pending[0] = 1;
    wait_valid(2);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(is_valid_o), 64'd0);
    check("midrst_gnt", 64'(gnt_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_ack", 64'(flit_ack_o), 64'd0);
    check("midrst_data", 64'(data_o), 64'd0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int r = 0; r < NR; r++) exp_idx[r] = 0;
    @(posedge clk);
    #1;
    len_i[0] = LW'(1);
    len_i[1] = LW'(2);
    push_pkt(0, 1, 0);
    push_pkt(1, 2, 0);
    pending[0] = 1;
    pending[1] = 1;
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_injection_scheduler.md
Name: node_injection_scheduler

Overview:
- Per-node injection controller driving one mesh local-port input: data, is_valid and the per-VC on/off and allocatable feedback.
- Shares that single local port among NUM_REQ traffic sources using packet-level round-robin arbitration.
- Allocates one VC per packet, splits each packet into HEAD/BODY/TAIL (or HEADTAIL) flits, and honours per-VC on/off flow control.

Parameters:
- NUM_REQ, 4, number of requesters sharing the local port (>=2).
- MAX_PKT_LEN, 8, maximum flits per packet (>=1).
- LEN_W, $clog2(MAX_PKT_LEN+1), width of the length field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  [NUM_REQ]  requester r has a packet pending
- x_dest_i  in  [NUM_REQ][DEST_ADDR_SIZE_X]  destination column, per requester
- y_dest_i  in  [NUM_REQ][DEST_ADDR_SIZE_Y]  destination row, per requester
- len_i  in  [NUM_REQ][LEN_W]  packet length in flits, per requester
- payload_i  in  [NUM_REQ][FLIT_DATA_SIZE]  current flit payload word, per requester
- flit_ack_o  out  [NUM_REQ]  combinational one-hot; the payload word is consumed at this edge
- gnt_o  out  [NUM_REQ]  registered one-hot; requester owning the port
- done_o  out  [NUM_REQ]  one-cycle pulse, coincident with the tail flit on data_o
- busy_o  out  1  high while in SEND
- data_o  out  flit_t  flit into the router local port
- is_valid_o  out  1  data_o valid
- is_on_off_i  in  [VC_NUM]  per-VC on/off credit from the local port
- is_allocatable_i  in  [VC_NUM]  per-VC free indication from the local port

Behaviour:
- Reset (sync, active-high): state=IDLE, rr pointer=0. gnt_o, done_o, flit_ack_o, busy_o and is_valid_o are 0; data_o is all-zero. Any in-flight packet is abandoned with no tail.
- FSM states:
  - IDLE: is_valid_o=0, gnt_o=0.
  - Eligible requester: req_i[r]=1. Eligible VC: is_allocatable_i[v] & is_on_off_i[v].
  - If at least one eligible requester and one eligible VC exist, at the edge: winner w is latched (first eligible requester at or after the rr pointer, wrapping).
  - At the same edge, cur_vc latches the lowest-index eligible VC; len latches len_i[w]; cnt=0; gnt_o=onehot(w); rr pointer=(w+1) mod NUM_REQ; state moves to SEND.
  - Otherwise the FSM stays in IDLE. Nothing is latched and the pointer is unchanged.
- SEND state:
  - busy_o=1. flit_ack_o[cur_req] = is_on_off_i[cur_vc], combinational.
  - At each edge with is_on_off_i[cur_vc]=1: data_o/is_valid_o are registered with flit cnt, vc_id=cur_vc, and cnt increments.
  - At each edge with is_on_off_i[cur_vc]=0: is_valid_o=0 next cycle and cnt holds (stall).
- Flit label:
  - len==1 gives HEADTAIL.
  - Otherwise cnt==0 gives HEAD, cnt==len-1 gives TAIL, and any other cnt gives BODY.
- Head/HEADTAIL data fields: head_data.x_dest = x_dest_i[cur_req]; head_data.y_dest = y_dest_i[cur_req]; head_pl = payload_i[cur_req][HEAD_PAYLOAD_SIZE-1:0]. Destination is sampled when the head is sent.
- BODY/TAIL data: bt_pl = payload_i[cur_req].
- Last flit edge: the edge that emits the tail/HEADTAIL sets state=IDLE. gnt_o=0 and done_o[cur_req]=1 for one cycle, aligned with the tail on data_o.
- Throughput and latency:
  - Minimum of one idle cycle between packets.
  - Head flit appears 2 cycles after req_i rises if the port is free and a VC is eligible.
  - Packet of length L with no stalls takes L cycles of valid output.
- Length rules: len_i==0 is treated as 1. len_i>MAX_PKT_LEN is clamped to MAX_PKT_LEN. len is sampled only at grant.
- req_i deassert mid-packet is ignored; the packet completes.
- VC changes: changes on is_allocatable_i during SEND are ignored. The VC is fixed per packet.
- The same requester may win again next arbitration only if no other requester is eligible.
- No eligible VC: requests wait in IDLE indefinitely. There is no timeout.

Test Plan:
- Single requester: req 0 asserted, len=3, dest (1,2), all VCs free and on -> HEAD/BODY/TAIL on 3 consecutive cycles with vc_id=0, flit_ack_o[0] high for 3 cycles, done_o[0] with the tail, then one idle cycle.
- len=1 (and len=0) on requester 2 -> single HEADTAIL flit with x/y dest and head_pl = low payload bits; done_o[2] in the same cycle.
- All 4 requesters held high, len=2 -> grant order 0,1,2,3,0. Packets never interleave; one bubble between packets; gnt_o always one-hot.
- Stall: is_allocatable_i=4'b1110, is_on_off_i[1] dropped for 2 cycles mid len=4 packet -> vc_id=1, is_valid_o gap of 2 cycles, no ack during the gap, flit order preserved, TAIL last.
- No eligible VC: is_allocatable_i=0 with req pending for 10 cycles -> no grant, is_valid_o=0. The allocatable bit rises and the head appears 2 cycles later.
- Reset mid-packet (after HEAD+BODY of len=5) -> next cycle all outputs 0, state IDLE, rr pointer 0. A new request restarts with HEAD and grant goes to requester 0 first.
